regfile_mp_rdy: RTL and testbench

Parametrised multi-port physical register file with a per-register ready scoreboard, for the out-of-order core's issue/execute stage. Generalises the fixed 8-read/4-write file to configurable port counts, data width and depth. Adds asynchronous reset, deterministic write-port conflict resolution, rename-time ready-bit clearing and optional write-to-read bypass. Register 0 reads as zero and is always ready.

---
 rtl/regfile_mp_rdy.sv | 90 +++++++++
 tb/tb_regfile_mp_rdy.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_rdy.sv
// regfile_mp_rdy: multi-port physical register file with a per-register ready scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp_rdy #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int NR     = 8,
  parameter int NW     = 4,
  parameter int NA     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NR*ADDR_W-1:0] i_raddr,
  output logic [NR*DATA_W-1:0] o_rdata,
  output logic [NR-1:0]        o_rready,
  input  logic [NW-1:0]        i_we,
  input  logic [NW*ADDR_W-1:0] i_waddr,
  input  logic [NW*DATA_W-1:0] i_wdata,
  input  logic [NA-1:0]        i_alloc,
  input  logic [NA*ADDR_W-1:0] i_aaddr,
  output logic                 o_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Entry 0 is hardwired (zero data, always ready) and has no storage.
  logic [DATA_W-1:0] mem_q [1:DEPTH-1];
  logic [DEPTH-1:1]  rdy_q;
  logic              conflict_p0;

  always_comb begin
    conflict_p0 = 1'b0;
    for (int a = 0; a < NW; a++) begin
      for (int b = a + 1; b < NW; b++) begin
        if (i_we[a] && i_we[b] &&
            (i_waddr[a*ADDR_W +: ADDR_W] == i_waddr[b*ADDR_W +: ADDR_W]) &&
            (i_waddr[a*ADDR_W +: ADDR_W] != '0)) begin
          conflict_p0 = 1'b1;
        end
      end
    end
  end

  // ---- stage boundary: state update at the clock edge ----
  // Later ports overwrite earlier ones, so the highest-index writer wins;
  // allocates are applied after writes so a same-address allocate leaves ready at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdy_q      <= '1;
      o_conflict <= 1'b0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (i_we[j] && (i_waddr[j*ADDR_W +: ADDR_W] != '0)) begin
          mem_q[i_waddr[j*ADDR_W +: ADDR_W]] <= i_wdata[j*DATA_W +: DATA_W];
          rdy_q[i_waddr[j*ADDR_W +: ADDR_W]] <= 1'b1;
        end
      end
      for (int m = 0; m < NA; m++) begin
        if (i_alloc[m] && (i_aaddr[m*ADDR_W +: ADDR_W] != '0)) begin
          rdy_q[i_aaddr[m*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      o_conflict <= conflict_p0;
    end
  end

  // ---- combinational read ports ----
  // Reads are forced to zero/ready while reset is held so a bypassed write cannot leak through.
  always_comb begin
    o_rdata  = '0;
    o_rready = '1;
    for (int k = 0; k < NR; k++) begin
      if (i_rst_n && (i_raddr[k*ADDR_W +: ADDR_W] != '0)) begin
        o_rdata[k*DATA_W +: DATA_W] = mem_q[i_raddr[k*ADDR_W +: ADDR_W]];
        o_rready[k]                 = rdy_q[i_raddr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NW; j++) begin
          if (i_we[j] && (i_waddr[j*ADDR_W +: ADDR_W] == i_raddr[k*ADDR_W +: ADDR_W])) begin
            o_rdata[k*DATA_W +: DATA_W] = i_wdata[j*DATA_W +: DATA_W];
            o_rready[k]                 = 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_rdy.sv
// Randomized scoreboard bench for regfile_mp_rdy against an array-based reference model.
module tb_regfile_mp_rdy;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int NR    = 8;
  localparam int NW    = 4;
  localparam int NA    = 2;
  localparam int DEPTH = 2 ** AW;

  logic             clk;
  logic             rst_n;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rready;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NA-1:0]    alloc;
  logic [NA*AW-1:0] aaddr;
  logic             conflict;

  regfile_mp_rdy #(.DATA_W(DW), .ADDR_W(AW), .NR(NR), .NW(NW), .NA(NA)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_raddr(raddr), .o_rdata(rdata), .o_rready(rready),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_alloc(alloc), .i_aaddr(aaddr),
    .o_conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rready;
    logic             conf;
  } exp_t;
  exp_t exp_q[$];

  // Stimulus for the next cycle
  logic [AW-1:0] s_raddr [NR];
  logic          s_we    [NW];
  logic [AW-1:0] s_waddr [NW];
  logic [DW-1:0] s_wdata [NW];
  logic          s_alloc [NA];
  logic [AW-1:0] s_aaddr [NA];

  // Reference state
  logic [DW-1:0] mm [DEPTH];
  logic          mr [DEPTH];
  logic          m_conf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mm[i] = '0;
      mr[i] = 1'b1;
    end
    m_conf = 1'b0;
  endtask

  task automatic clr_stim();
    for (int j = 0; j < NW; j++) begin
      s_we[j] = 1'b0; s_waddr[j] = '0; s_wdata[j] = '0;
    end
    for (int m = 0; m < NA; m++) begin
      s_alloc[m] = 1'b0; s_aaddr[m] = '0;
    end
  endtask

  task automatic set_reads(input logic [AW-1:0] a);
    for (int k = 0; k < NR; k++) s_raddr[k] = a;
  endtask

  task automatic apply_stim();
    for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = s_raddr[k];
    for (int j = 0; j < NW; j++) begin
      we[j] = s_we[j];
      waddr[j*AW +: AW] = s_waddr[j];
      wdata[j*DW +: DW] = s_wdata[j];
    end
    for (int m = 0; m < NA; m++) begin
      alloc[m] = s_alloc[m];
      aaddr[m*AW +: AW] = s_aaddr[m];
    end
  endtask

  // One normal cycle: drive at negedge, predict outputs, then advance the model past the edge.
  task automatic step();
    exp_t e;
    int   hits [DEPTH];
    logic done [DEPTH];
    @(negedge clk);
    rst_n = 1'b1;
    apply_stim();
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          r;
      a = s_raddr[k];
      d = (a == 0) ? '0 : mm[a];
      r = (a == 0) ? 1'b1 : mr[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = NW - 1; j >= 0; j--) begin
        if (a != 0 && s_we[j] && s_waddr[j] == a) begin
          d = s_wdata[j]; r = 1'b1;
          break;
        end
      end
`endif
      e.rdata[k*DW +: DW] = d;
      e.rready[k] = r;
    end
    e.conf = m_conf;
    exp_q.push_back(e);
    for (int i = 0; i < DEPTH; i++) begin
      hits[i] = 0; done[i] = 1'b0;
    end
    for (int j = NW - 1; j >= 0; j--) begin
      if (s_we[j] && s_waddr[j] != 0) begin
        hits[s_waddr[j]]++;
        if (!done[s_waddr[j]]) begin
          mm[s_waddr[j]] = s_wdata[j];
          mr[s_waddr[j]] = 1'b1;
          done[s_waddr[j]] = 1'b1;
        end
      end
    end
    for (int m = 0; m < NA; m++)
      if (s_alloc[m] && s_aaddr[m] != 0) mr[s_aaddr[m]] = 1'b0;
    m_conf = 1'b0;
    for (int i = 1; i < DEPTH; i++) if (hits[i] > 1) m_conf = 1'b1;
  endtask

  // Cycle where reset lands mid-cycle while writes are being presented.
  task automatic step_rst();
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stim();
    #1 rst_n = 1'b0;
    e.rdata  = '0;
    e.rready = '1;
    e.conf   = 1'b0;
    exp_q.push_back(e);
    model_reset();
  endtask

  // Monitor: samples away from the rising edge and checks against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (rdata !== e.rdata) begin
          n_bad++;
          $display("FAIL rdata @%0t: got %h want %h", $time, rdata, e.rdata);
        end
        n_cmp++;
        if (rready !== e.rready) begin
          n_bad++;
          $display("FAIL rready @%0t: got %b want %b", $time, rready, e.rready);
        end
        n_cmp++;
        if (conflict !== e.conf) begin
          n_bad++;
          $display("FAIL conflict @%0t: got %b want %b", $time, conflict, e.conf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    raddr = '0; we = '0; waddr = '0; wdata = '0; alloc = '0; aaddr = '0;
    model_reset();
    clr_stim();
    set_reads('0);

    // Reset state on addresses 0, 1, 63
    for (int k = 0; k < NR; k++) s_raddr[k] = (k % 3 == 0) ? 6'd0 : (k % 3 == 1) ? 6'd1 : 6'd63;
    step();
    // Write port 2 addr 5
    set_reads(6'd5);
    s_we[2] = 1'b1; s_waddr[2] = 6'd5; s_wdata[2] = 32'hDEADBEEF;
    step();
    clr_stim(); step();
    // Write to addr 0 is dropped
    set_reads(6'd0);
    s_we[0] = 1'b1; s_waddr[0] = 6'd0; s_wdata[0] = 32'h00001234;
    step();
    clr_stim(); step();
    // Conflict on addr 9
    set_reads(6'd9);
    s_we[0] = 1'b1; s_waddr[0] = 6'd9; s_wdata[0] = 32'h11111111;
    s_we[3] = 1'b1; s_waddr[3] = 6'd9; s_wdata[3] = 32'h33333333;
    step();
    clr_stim(); step(); step();
    // Allocate / write interplay on addr 12
    set_reads(6'd12);
    s_alloc[0] = 1'b1; s_aaddr[0] = 6'd12;
    step();
    clr_stim(); step();
    s_we[1] = 1'b1; s_waddr[1] = 6'd12; s_wdata[1] = 32'hA5A5A5A5;
    step();
    clr_stim(); step();
    s_alloc[1] = 1'b1; s_aaddr[1] = 6'd12;
    s_alloc[0] = 1'b1; s_aaddr[0] = 6'd12;
    s_we[1] = 1'b1; s_waddr[1] = 6'd12; s_wdata[1] = 32'h5A5A5A5A;
    step();
    clr_stim(); step();
    // Same-cycle write and read of addr 20
    set_reads(6'd20);
    s_we[0] = 1'b1; s_waddr[0] = 6'd20; s_wdata[0] = 32'hCAFEF00D;
    step();
    clr_stim(); step();
    // Reset mid-cycle with a write pending
    set_reads(6'd5);
    s_we[3] = 1'b1; s_waddr[3] = 6'd5; s_wdata[3] = 32'h77777777;
    step_rst();
    clr_stim(); step();

    // Randomized traffic on a narrow address window to provoke collisions
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NR; k++)
        s_raddr[k] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      for (int j = 0; j < NW; j++) begin
        s_we[j]    = ($urandom_range(0, 1) == 1);
        s_waddr[j] = AW'($urandom_range(0, 15));
        s_wdata[j] = $urandom;
      end
      for (int m = 0; m < NA; m++) begin
        s_alloc[m] = ($urandom_range(0, 3) == 0);
        s_aaddr[m] = AW'($urandom_range(0, 15));
      end
      if (c == 217) step_rst();
      else step();
    end

    clr_stim();
    step();
    repeat (2) @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
